ula_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for R-type MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO.
- Sits beside the ALU in the execute stage and owns the architectural HI/LO registers.
- Multiplication uses shift-add and division uses restoring division, both at one bit per cycle.
- Exposes a start/busy/done handshake so the pipeline control can stall on busy.

---
 rtl/ula_muldiv.sv | 177 +++++++++++++++++
 tb/tb_ula_muldiv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide at one bit per cycle, with start/busy/done handshake.
module ula_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_wh, r_wl, r_mag, r_a_orig, r_hi, r_lo;
  logic               r_sign_q, r_sign_r, r_is_div, r_zero, r_done, r_div_zero;
  logic               w_accept, w_mthi, w_mtlo, w_step, w_finish;
  logic               w_is_md, w_is_signed, w_is_div, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_wh_next, w_wl_next, w_res_hi, w_res_lo;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_md     = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
  assign w_is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign w_is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign w_abs_a     = (w_is_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b     = (w_is_signed && b[WIDTH-1]) ? -b : b;

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign rd_data  = (funct == F_MFHI) ? r_hi : r_lo;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control strobes; flush beats both start and completion
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (start && w_is_md) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end else begin
          w_mthi = start && (funct == F_MTHI);
          w_mtlo = start && (funct == F_MTLO);
        end
      end
      S_RUN: begin
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          w_next = (r_cnt == CNT_LAST) ? S_FIX : S_RUN;
        end
      end
      S_FIX: begin
        w_next   = S_IDLE;
        w_finish = !flush;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One iteration: multiply keeps {acc, multiplier} shifting right,
  // divide keeps {remainder, dividend/quotient} shifting left
  always_comb begin
    w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_mag} : {(WIDTH+1){1'b0}});
    w_shift = {r_wh, r_wl[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_mag};
    w_ge    = (w_shift >= {1'b0, r_mag});
    if (r_is_div) begin
      w_wh_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_wl_next = {r_wl[WIDTH-2:0], w_ge};
    end else begin
      w_wh_next = w_sum[WIDTH:1];
      w_wl_next = {w_sum[0], r_wl[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero substitution
  always_comb begin
    w_prod = r_sign_q ? -{r_wh, r_wl} : {r_wh, r_wl};
    if (!r_is_div) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_zero) begin
      w_res_hi = r_a_orig;
      w_res_lo = {WIDTH{1'b1}};
    end else begin
      w_res_hi = r_sign_r ? -r_wh : r_wh;
      w_res_lo = r_sign_q ? -r_wl : r_wl;
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_wh       <= '0;
      r_wl       <= '0;
      r_mag      <= '0;
      r_a_orig   <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_is_div   <= 1'b0;
      r_zero     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_cnt      <= '0;
        r_div_zero <= 1'b0;
        r_wh       <= '0;
        r_wl       <= w_is_div ? w_abs_a : w_abs_b;
        r_mag      <= w_is_div ? w_abs_b : w_abs_a;
        r_a_orig   <= a;
        r_is_div   <= w_is_div;
        r_zero     <= w_is_div && (b == '0);
        r_sign_q   <= w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_sign_r   <= w_is_signed && a[WIDTH-1];
      end else if (w_step) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
        r_wh  <= w_wh_next;
        r_wl  <= w_wl_next;
      end else if (w_finish) begin
        r_hi       <= w_res_hi;
        r_lo       <= w_res_lo;
        r_div_zero <= r_zero;
      end else begin
        if (w_mthi) r_hi <= a;
        if (w_mtlo) r_lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_ula_muldiv.sv
// Scoreboard bench for ula_muldiv: directed mul/div vectors, MT/MF access,
// flush, asynchronous reset and a WIDTH=8 instance.
module tb_ula_muldiv;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, start8 = 1'b0;
  logic [5:0] funct = 6'h00;
  logic [W-1:0] a = '0, b = '0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic busy, done, div_zero, busy8, done8, div_zero8;
  logic [W-1:0] hi, lo, rd_data;
  logic [7:0] hi8, lo8, rd_data8;

  typedef struct packed { logic [W-1:0] hi; logic [W-1:0] lo; logic dz; } exp_t;
  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0;

  ula_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo), .rd_data(rd_data));

  ula_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .funct(funct), .a(a8), .b(b8), .flush(flush),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8), .rd_data(rd_data8));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  // Issue one mul/div at the current negedge and return at the done cycle
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input string name);
    int n;
    funct = f; a = va; b = vb; start = 1'b1;
    sbq.push_back('{hi: ehi, lo: elo, dz: edz});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'd33);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
    run_op(F_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg");
    run_op(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
    run_op(F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu");
    run_op(F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "div_negb");
    run_op(F_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, "divu_zero");
    run_op(F_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, "multu_small");
    run_op(F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, "div_zero_s");
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, "div_ovf");

    // Flush mid-RUN with an MTLO held during busy
    funct = F_MULTU; a = 32'd5; b = 32'd7; start = 1'b1;
    @(negedge clk);
    funct = F_MTLO; a = 32'h0000DEAD;
    repeat (8) @(negedge clk);
    check("busy_before_flush", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {32'd0, 32'h80000000});
    repeat (3) @(negedge clk);
    check("flush_lo_kept", 64'(lo), 64'h80000000);

    funct = F_MTHI; a = 32'h00001234; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct = F_MFHI;
    #1;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mfhi_rd", 64'(rd_data), 64'h1234);
    funct = F_MFLO;
    #1;
    check("mflo_rd", 64'(rd_data), 64'h80000000);
    @(negedge clk);

    // Flush on the completion edge: no done, HI/LO kept
    funct = F_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("busy_in_fix", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fix_flush_busy", 64'(busy), 64'd0);
    check("fix_flush_hilo", {hi, lo}, {32'h1234, 32'h80000000});

    // Flush together with start in IDLE drops the start
    funct = F_MTLO; a = 32'd77; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_drops_mtlo", 64'(lo), 64'h80000000);

    // Asynchronous reset between edges mid-RUN
    funct = F_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 64'(busy), 64'd0);
    check("async_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=8 instance
    funct = F_MULTU; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("w8_busy_cycles", 64'(n), 64'd9);
    check("w8_done", 64'(done8), 64'd1);
    check("w8_hilo", 64'({hi8, lo8}), 64'h0000_0000_0000_FE01);
    check("w8_dz", 64'(div_zero8), 64'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
